// File: rtl/usb_ulpi_pad_ctrl_pkg.sv
// usb_ulpi_pkg: state encoding and default strap pattern shared by the ULPI pad controller.
package usb_ulpi_pkg;
  typedef enum logic [1:0] {
    ST_RST_ASSERT = 2'd0,
    ST_STRAP_HOLD = 2'd1,
    ST_WAIT_CLK   = 2'd2,
    ST_RUN        = 2'd3
  } state_e;
  localparam logic [7:0] STRAP_DEFAULT = 8'b0011_0000;
endpackage

// File: rtl/usb_ulpi_pad_ctrl_if.sv
// usb_ulpi_pad_ctrl_if: pad-side bus between the link, the pad controller and the PHY pads.
interface usb_ulpi_pad_ctrl_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] link_d_out;
  logic [DATA_W-1:0] pad_d_out;
  logic link_d_oe;
  logic pad_d_oe;
  logic phy_reset_n;
  logic reset_n_out;
  modport master (input link_d_out, link_d_oe, output pad_d_out, pad_d_oe, phy_reset_n, reset_n_out);
  modport slave (output link_d_out, link_d_oe, input pad_d_out, pad_d_oe, phy_reset_n, reset_n_out);
endinterface

// File: rtl/usb_ulpi_pad_ctrl_clk_mon.sv
// usb_clk_mon: synchronises the PHY clock monitor, counts its edges and flags a stalled clock.
module usb_clk_mon #(
  parameter int CLK_EDGES   = 8,
  parameter int CLK_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic mon_i,
  input  logic clr_i,
  output logic done_o,
  output logic timeout_o
);
  localparam int EW = $clog2(CLK_EDGES + 1);
  localparam int IW = $clog2(CLK_TIMEOUT + 1);
  logic [2:0] sync_q;
  logic [EW-1:0] edges_q;
  logic [IW-1:0] idle_q;
  logic rise;
  assign rise = sync_q[1] & ~sync_q[2];
  assign done_o = rise && edges_q == EW'(CLK_EDGES - 1);
  // an edge in the same cycle as the last idle tick keeps the clock alive
  assign timeout_o = !rise && idle_q == IW'(CLK_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      edges_q <= '0;
      idle_q  <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], mon_i};
      edges_q <= clr_i ? '0 : edges_q + EW'(rise && edges_q != EW'(CLK_EDGES));
      idle_q  <= clr_i || rise ? '0 : idle_q + IW'(idle_q != IW'(CLK_TIMEOUT));
    end
endmodule

// File: rtl/usb_ulpi_pad_ctrl.sv
// usb_ulpi_pad_ctrl: PHY reset/strap sequencer with clock-alive check and watchdog re-bring-up.
// Define USB_ULPI_PAD_CTRL_STATUS_EN to add the stat_retries and stat_clk_lost outputs.
module usb_ulpi_pad_ctrl
  import usb_ulpi_pkg::*;
#(
  parameter int         DATA_W            = 8,
  parameter logic [7:0] STRAP_VALUE       = STRAP_DEFAULT,
  parameter int         RST_CYCLES        = 64,
  parameter int         STRAP_HOLD_CYCLES = 16,
  parameter int         CLK_EDGES         = 8,
  parameter int         CLK_TIMEOUT       = 4096,
  parameter int         MAX_RETRY         = 3
) (
  usb_ulpi_pad_ctrl_if.master bus,
  input  logic ext_clk,
  input  logic reset,
  input  logic phy_clk_mon,
  input  logic opt_disable_all,
  input  logic opt_restart,
  output logic [1:0] stat_state,
  output logic stat_fail
`ifdef USB_ULPI_PAD_CTRL_STATUS_EN
  ,
  output logic [$clog2(MAX_RETRY+1)-1:0] stat_retries,
  output logic [7:0] stat_clk_lost
`endif
);
  localparam int CW = $clog2((RST_CYCLES > STRAP_HOLD_CYCLES ? RST_CYCLES : STRAP_HOLD_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic fail_q, fail_d, phy_rst_n_q, oe_q, link_rst_n_q, done, timeout, clr;

  usb_clk_mon #(.CLK_EDGES(CLK_EDGES), .CLK_TIMEOUT(CLK_TIMEOUT)) u_clk_mon (
    .clk(ext_clk), .rst(reset), .mon_i(phy_clk_mon), .clr_i(clr), .done_o(done), .timeout_o(timeout)
  );

  assign clr = state_d != state_q || !(state_q inside {ST_WAIT_CLK, ST_RUN});

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    fail_d  = fail_q;
    if (opt_restart) begin
      state_d = ST_RST_ASSERT;
      retry_d = '0;
      fail_d  = 1'b0;
    end else if (opt_disable_all) begin
      state_d = ST_RST_ASSERT;
      cnt_d   = state_q == ST_RST_ASSERT ? cnt_q : '0;
    end else begin
      case (state_q)
        ST_RST_ASSERT: if (!fail_q) begin
          state_d = cnt_q == CW'(RST_CYCLES - 1) ? ST_STRAP_HOLD : ST_RST_ASSERT;
          cnt_d   = state_d == ST_RST_ASSERT ? cnt_q + CW'(1) : '0;
        end
        ST_STRAP_HOLD: begin
          state_d = cnt_q == CW'(STRAP_HOLD_CYCLES - 1) ? ST_WAIT_CLK : ST_STRAP_HOLD;
          cnt_d   = state_d == ST_STRAP_HOLD ? cnt_q + CW'(1) : '0;
        end
        ST_WAIT_CLK: if (done) state_d = ST_RUN;
        else if (timeout) begin
          state_d = ST_RST_ASSERT;
          retry_d = retry_q + RW'(1);
          fail_d  = retry_d == RW'(MAX_RETRY);
        end
        default: if (timeout) begin
          state_d = ST_RST_ASSERT;
          retry_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ext_clk or posedge reset)
    if (reset) begin
      state_q      <= ST_RST_ASSERT;
      cnt_q        <= '0;
      retry_q      <= '0;
      fail_q       <= 1'b0;
      phy_rst_n_q  <= 1'b0;
      oe_q         <= 1'b1;
      link_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      fail_q       <= fail_d;
      phy_rst_n_q  <= state_d != ST_RST_ASSERT;
      oe_q         <= state_d inside {ST_RST_ASSERT, ST_STRAP_HOLD};
      link_rst_n_q <= state_d == ST_RUN;
    end

  assign bus.phy_reset_n = phy_rst_n_q;
  assign bus.reset_n_out = link_rst_n_q;
  assign bus.pad_d_out   = state_q == ST_RUN ? bus.link_d_out : STRAP_VALUE[DATA_W-1:0];
  assign bus.pad_d_oe    = state_q == ST_RUN ? bus.link_d_oe : oe_q;
  assign stat_state      = state_q;
  assign stat_fail       = fail_q;

`ifdef USB_ULPI_PAD_CTRL_STATUS_EN
  logic [7:0] lost_q;
  always_ff @(posedge ext_clk or posedge reset)
    if (reset) lost_q <= '0;
    else if (state_q == ST_RUN && timeout && !opt_restart && !opt_disable_all && lost_q != 8'hFF)
      lost_q <= lost_q + 8'd1;
  assign stat_retries  = retry_q;
  assign stat_clk_lost = lost_q;
`endif
endmodule
